// File: rtl/l3_cmd_seq_if.sv
// l3_cmd_seq_if: host-side bundle of the L3 command sequencer.
//   Request channel : req_valid / req_ready / req_cmd, plus level-sampled abort_req.
//   Response channel: rsp_valid / rsp_ready / rsp_status / rsp_retries.
//   master modport  : host side (drives request, consumes response).
//   slave modport   : sequencer side.
interface l3_cmd_seq_if #(
  parameter int CMD_W = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [CMD_W-1:0] req_cmd;
  logic             abort_req;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_status;
  logic [1:0]       rsp_retries;

  modport master (
    output req_valid, req_cmd, abort_req, rsp_ready,
    input  req_ready, rsp_valid, rsp_status, rsp_retries
  );

  modport slave (
    input  req_valid, req_cmd, abort_req, rsp_ready,
    output req_ready, rsp_valid, rsp_status, rsp_retries
  );
endinterface

// File: rtl/l3_cmd_seq.sv
// l3_cmd_seq: issues one host command at a time to an L3 engine, supervised by
// an external watchdog. Timeouts abort the engine and re-issue the command after
// an idle gap, up to MAX_RETRY times; the host may cancel at any point while the
// command is outstanding. A single response reports OK / TIMEOUT_FAIL / ABORTED
// and the number of re-issues used.
//
// Ports:
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   host         : l3_cmd_seq_if.slave (request, abort, response handshakes)
//   cmd_start    : one-cycle pulse, engine begins cmd_out
//   cmd_out      : latched command word
//   cmd_done     : engine completion pulse (also wired to the watchdog)
//   cmd_abort    : one-cycle pulse, engine drops the current command
//   l3_en        : one-cycle pulse, watchdog clears and starts
//   timer_stop   : one-cycle pulse, watchdog clears and stops
//   err_timeout  : watchdog expiry pulse
module l3_cmd_seq #(
  parameter int CMD_W     = 8,
  parameter int MAX_RETRY = 2,
  parameter int GAP_CYC   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  l3_cmd_seq_if.slave      host,
  output logic             cmd_start,
  output logic [CMD_W-1:0] cmd_out,
  input  logic             cmd_done,
  output logic             cmd_abort,
  output logic             l3_en,
  output logic             timer_stop,
  input  logic             err_timeout
);

  typedef enum logic [2:0] {IDLE, START, WAIT, GAP, RESP} state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_ABORTED = 2'b10;

  localparam logic [1:0] MAX_R    = 2'(MAX_RETRY);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYC - 1);

  state_t     state;
  logic [1:0] retry_cnt;
  logic [3:0] gap_cnt;

  // The abort-type pulses must coincide with the event that causes them, so
  // they are decoded from the current state and inputs rather than registered.
  // cmd_done outranks everything in WAIT; a GAP abort needs no cmd_abort since
  // the engine was already dropped by the timeout that led into GAP.
  assign cmd_abort  = (state == WAIT) && !cmd_done && (err_timeout || host.abort_req);
  assign timer_stop = ((state == WAIT) && !cmd_done && !err_timeout && host.abort_req) ||
                      ((state == GAP) && host.abort_req);

  assign host.rsp_retries = retry_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      host.req_ready  <= 1'b1;
      host.rsp_valid  <= 1'b0;
      host.rsp_status <= ST_OK;
      cmd_start       <= 1'b0;
      l3_en           <= 1'b0;
      cmd_out         <= '0;
      retry_cnt       <= '0;
      gap_cnt         <= '0;
    end else begin
      cmd_start <= 1'b0;
      l3_en     <= 1'b0;
      case (state)
        IDLE: begin
          if (host.req_valid) begin
            cmd_out        <= host.req_cmd;
            retry_cnt      <= '0;
            host.req_ready <= 1'b0;
            cmd_start      <= 1'b1;
            l3_en          <= 1'b1;
            state          <= START;
          end
        end
        START: state <= WAIT;
        WAIT: begin
          if (cmd_done) begin
            host.rsp_status <= ST_OK;
            host.rsp_valid  <= 1'b1;
            state           <= RESP;
          end else if (err_timeout) begin
            // retry_cnt only advances while below MAX_R, so it saturates there.
            if (retry_cnt < MAX_R) begin
              retry_cnt <= retry_cnt + 2'd1;
              gap_cnt   <= '0;
              state     <= GAP;
            end else begin
              host.rsp_status <= ST_TIMEOUT;
              host.rsp_valid  <= 1'b1;
              state           <= RESP;
            end
          end else if (host.abort_req) begin
            host.rsp_status <= ST_ABORTED;
            host.rsp_valid  <= 1'b1;
            state           <= RESP;
          end
        end
        GAP: begin
          if (host.abort_req) begin
            host.rsp_status <= ST_ABORTED;
            host.rsp_valid  <= 1'b1;
            state           <= RESP;
          end else if (gap_cnt == GAP_LAST) begin
            cmd_start <= 1'b1;
            l3_en     <= 1'b1;
            state     <= START;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        RESP: begin
          if (host.rsp_ready) begin
            host.rsp_valid <= 1'b0;
            host.req_ready <= 1'b1;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l3_cmd_seq.sv
module tb_l3_cmd_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Main DUT: MAX_RETRY=2, GAP_CYC=4
  l3_cmd_seq_if #(.CMD_W(8)) bus ();
  logic       cmd_start, cmd_abort, l3_en, timer_stop;
  logic [7:0] cmd_out;
  logic       cmd_done, err_timeout;

  l3_cmd_seq #(.CMD_W(8), .MAX_RETRY(2), .GAP_CYC(4)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .host       (bus),
    .cmd_start  (cmd_start),
    .cmd_out    (cmd_out),
    .cmd_done   (cmd_done),
    .cmd_abort  (cmd_abort),
    .l3_en      (l3_en),
    .timer_stop (timer_stop),
    .err_timeout(err_timeout)
  );

  // Second DUT: MAX_RETRY=0
  l3_cmd_seq_if #(.CMD_W(8)) bus0 ();
  logic       cmd_start0, cmd_abort0, l3_en0, timer_stop0;
  logic [7:0] cmd_out0;
  logic       cmd_done0, err_timeout0;

  l3_cmd_seq #(.CMD_W(8), .MAX_RETRY(0), .GAP_CYC(1)) u_dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .host       (bus0),
    .cmd_start  (cmd_start0),
    .cmd_out    (cmd_out0),
    .cmd_done   (cmd_done0),
    .cmd_abort  (cmd_abort0),
    .l3_en      (l3_en0),
    .timer_stop (timer_stop0),
    .err_timeout(err_timeout0)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Pulse counters and pulse-rule monitor (main DUT)
  int   n_start = 0;
  int   n_abort = 0;
  int   viol    = 0;
  logic p_start = 1'b0, p_abort = 1'b0, p_en = 1'b0, p_stop = 1'b0;

  always @(posedge clk) begin
    n_start <= n_start + int'(cmd_start);
    n_abort <= n_abort + int'(cmd_abort);
    if ((cmd_start && p_start) || (cmd_abort && p_abort) || (l3_en && p_en) ||
        (timer_stop && p_stop) || (l3_en && timer_stop))
      viol <= viol + 1;
    p_start <= cmd_start;
    p_abort <= cmd_abort;
    p_en    <= l3_en;
    p_stop  <= timer_stop;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic handshake();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_tests++;
    if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %0b exp 1", bus.req_ready); end
    n_tests++;
    if ({cmd_start, cmd_abort, l3_en, timer_stop, bus.rsp_valid} !== 5'b0) begin
      n_fail++; $display("FAIL reset_pulses got %05b exp 00000", {cmd_start, cmd_abort, l3_en, timer_stop, bus.rsp_valid});
    end
    n_tests++;
    if ({bus.rsp_status, bus.rsp_retries, cmd_out} !== 12'h000) begin
      n_fail++; $display("FAIL reset_fields got %03h exp 000", {bus.rsp_status, bus.rsp_retries, cmd_out});
    end
    rst_n = 1'b1;
  endtask

  // Acceptance on the first edge after reset release; timeline counted from cycle 0.
  task automatic test_nominal();
    bus.req_valid = 1'b1;
    bus.req_cmd   = 8'hA5;
    #1;
    n_tests++;
    if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL nom_req_ready got %0b exp 1", bus.req_ready); end
    tick();                                  // cycle 1
    bus.req_valid = 1'b0;
    n_tests++;
    if ({cmd_start, l3_en, cmd_out} !== {2'b11, 8'hA5}) begin
      n_fail++; $display("FAIL nom_start got start=%0b en=%0b cmd=%02h exp 1 1 a5", cmd_start, l3_en, cmd_out);
    end
    tick();                                  // cycle 2
    n_tests++;
    if ({cmd_start, l3_en} !== 2'b00) begin n_fail++; $display("FAIL nom_start_pulse got %02b exp 00", {cmd_start, l3_en}); end
    repeat (8) tick();                       // cycle 10
    cmd_done = 1'b1;
    #1;
    n_tests++;
    if ({cmd_abort, timer_stop} !== 2'b00) begin n_fail++; $display("FAIL nom_done_pulses got %02b exp 00", {cmd_abort, timer_stop}); end
    tick();                                  // cycle 11
    cmd_done = 1'b0;
    n_tests++;
    if ({bus.rsp_valid, bus.rsp_status, bus.rsp_retries, bus.req_ready} !== 6'b1_00_00_0) begin
      n_fail++; $display("FAIL nom_resp got v=%0b st=%0d rt=%0d rdy=%0b exp 1 0 0 0", bus.rsp_valid, bus.rsp_status, bus.rsp_retries, bus.req_ready);
    end
    handshake();                             // cycle 12
    n_tests++;
    if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
      n_fail++; $display("FAIL nom_after_hs got v=%0b rdy=%0b exp 0 1", bus.rsp_valid, bus.req_ready);
    end
  endtask

  task automatic test_single_retry();
    bus.req_valid = 1'b1;
    bus.req_cmd   = 8'hA5;
    tick();                                  // START
    bus.req_valid = 1'b0;
    tick();                                  // WAIT
    tick();                                  // WAIT
    err_timeout = 1'b1;
    #1;
    n_tests++;
    if ({cmd_abort, timer_stop} !== 2'b10) begin n_fail++; $display("FAIL retry_abort got %02b exp 10", {cmd_abort, timer_stop}); end
    tick();                                  // GAP 1
    err_timeout = 1'b0;
    repeat (3) tick();                       // GAP 4
    n_tests++;
    if ({cmd_start, l3_en, cmd_abort} !== 3'b000) begin n_fail++; $display("FAIL retry_gap4 got %03b exp 000", {cmd_start, l3_en, cmd_abort}); end
    tick();                                  // START again
    n_tests++;
    if ({cmd_start, l3_en, cmd_out} !== {2'b11, 8'hA5}) begin
      n_fail++; $display("FAIL retry_restart got start=%0b en=%0b cmd=%02h exp 1 1 a5", cmd_start, l3_en, cmd_out);
    end
    tick();                                  // WAIT
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    n_tests++;
    if ({bus.rsp_valid, bus.rsp_status, bus.rsp_retries} !== 5'b1_00_01) begin
      n_fail++; $display("FAIL retry_resp got v=%0b st=%0d rt=%0d exp 1 0 1", bus.rsp_valid, bus.rsp_status, bus.rsp_retries);
    end
    handshake();
  endtask

  task automatic test_exhausted();
    int s0, a0;
    s0 = n_start;
    a0 = n_abort;
    bus.req_valid = 1'b1;
    bus.req_cmd   = 8'h3C;
    tick();                                  // START
    bus.req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();                                // WAIT
      err_timeout = 1'b1;
      tick();                                // GAP 1, or RESP after the last
      err_timeout = 1'b0;
      if (k < 2) repeat (4) tick();          // -> START
    end
    n_tests++;
    if ({bus.rsp_valid, bus.rsp_status, bus.rsp_retries} !== 5'b1_01_10) begin
      n_fail++; $display("FAIL exh_resp got v=%0b st=%0d rt=%0d exp 1 1 2", bus.rsp_valid, bus.rsp_status, bus.rsp_retries);
    end
    n_tests++;
    if (n_start - s0 !== 3) begin n_fail++; $display("FAIL exh_starts got %0d exp 3", n_start - s0); end
    n_tests++;
    if (n_abort - a0 !== 3) begin n_fail++; $display("FAIL exh_aborts got %0d exp 3", n_abort - a0); end
    handshake();
  endtask

  task automatic test_abort();
    // Abort while waiting on the engine
    bus.req_valid = 1'b1;
    bus.req_cmd   = 8'h42;
    tick();
    bus.req_valid = 1'b0;
    tick();                                  // WAIT
    bus.abort_req = 1'b1;
    #1;
    n_tests++;
    if ({cmd_abort, timer_stop} !== 2'b11) begin n_fail++; $display("FAIL abw_pulses got %02b exp 11", {cmd_abort, timer_stop}); end
    tick();
    bus.abort_req = 1'b0;
    n_tests++;
    if ({bus.rsp_valid, bus.rsp_status, cmd_abort, timer_stop} !== 5'b1_10_00) begin
      n_fail++; $display("FAIL abw_resp got %05b exp 11000", {bus.rsp_valid, bus.rsp_status, cmd_abort, timer_stop});
    end
    handshake();
    // Abort held during the retry gap
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    tick();                                  // WAIT
    err_timeout = 1'b1;
    tick();                                  // GAP 1
    err_timeout   = 1'b0;
    bus.abort_req = 1'b1;
    #1;
    n_tests++;
    if ({cmd_abort, timer_stop} !== 2'b01) begin n_fail++; $display("FAIL abg_pulses got %02b exp 01", {cmd_abort, timer_stop}); end
    tick();
    n_tests++;
    if ({bus.rsp_valid, bus.rsp_status, bus.rsp_retries, cmd_abort, timer_stop} !== 7'b1_10_01_00) begin
      n_fail++; $display("FAIL abg_resp got %07b exp 1100100", {bus.rsp_valid, bus.rsp_status, bus.rsp_retries, cmd_abort, timer_stop});
    end
    bus.abort_req = 1'b0;
    handshake();
  endtask

  task automatic test_simultaneous();
    bus.req_valid = 1'b1;
    bus.req_cmd   = 8'h99;
    tick();                                  // START: engine inputs must be ignored
    bus.req_valid = 1'b0;
    cmd_done      = 1'b1;
    err_timeout   = 1'b1;
    tick();                                  // WAIT
    cmd_done      = 1'b0;
    err_timeout   = 1'b0;
    #1;
    n_tests++;
    if ({bus.rsp_valid, cmd_abort} !== 2'b00) begin n_fail++; $display("FAIL sim_start_ignore got %02b exp 00", {bus.rsp_valid, cmd_abort}); end
    cmd_done      = 1'b1;
    err_timeout   = 1'b1;
    bus.abort_req = 1'b1;
    #1;
    n_tests++;
    if ({cmd_abort, timer_stop} !== 2'b00) begin n_fail++; $display("FAIL sim_pulses got %02b exp 00", {cmd_abort, timer_stop}); end
    tick();
    cmd_done = 1'b0; err_timeout = 1'b0; bus.abort_req = 1'b0;
    n_tests++;
    if ({bus.rsp_valid, bus.rsp_status, bus.rsp_retries} !== 5'b1_00_00) begin
      n_fail++; $display("FAIL sim_resp got v=%0b st=%0d rt=%0d exp 1 0 0", bus.rsp_valid, bus.rsp_status, bus.rsp_retries);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    int bad = 0;
    bus.req_valid = 1'b1;
    bus.req_cmd   = 8'h5A;
    tick();
    bus.req_valid = 1'b0;
    tick();                                  // WAIT
    err_timeout = 1'b1;
    tick();                                  // GAP 1
    err_timeout = 1'b0;
    repeat (4) tick();                       // START
    tick();                                  // WAIT
    cmd_done = 1'b1;
    tick();                                  // RESP
    cmd_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.req_valid = 1'b1;
      cmd_done      = i[0];
      err_timeout   = i[1];
      bus.abort_req = i[2];
      #1;
      if ({bus.rsp_valid, bus.rsp_status, bus.rsp_retries, bus.req_ready, cmd_abort, timer_stop, cmd_start} !== 9'b1_00_01_0_000)
        bad++;
      tick();
    end
    bus.req_valid = 1'b0; cmd_done = 1'b0; err_timeout = 1'b0; bus.abort_req = 1'b0;
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL bp_hold got %0d bad cycles exp 0", bad); end
    handshake();
    n_tests++;
    if ({bus.rsp_valid, bus.req_ready, cmd_out} !== {2'b01, 8'h5A}) begin
      n_fail++; $display("FAIL bp_release got v=%0b rdy=%0b cmd=%02h exp 0 1 5a", bus.rsp_valid, bus.req_ready, cmd_out);
    end
  endtask

  task automatic test_reset_mid();
    bus.req_valid = 1'b1;
    bus.req_cmd   = 8'h77;
    tick();
    bus.req_valid = 1'b0;
    tick();                                  // WAIT
    tick();
    rst_n         = 1'b0;
    bus.abort_req = 1'b1;
    #1;
    n_tests++;
    if ({bus.req_ready, bus.rsp_valid, cmd_abort, timer_stop, cmd_start, l3_en, cmd_out} !== {6'b100000, 8'h00}) begin
      n_fail++; $display("FAIL rstmid_outputs got %014b exp 10000000000000", {bus.req_ready, bus.rsp_valid, cmd_abort, timer_stop, cmd_start, l3_en, cmd_out});
    end
    tick();
    bus.abort_req = 1'b0;
    rst_n         = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_cmd   = 8'h11;
    tick();
    bus.req_valid = 1'b0;
    n_tests++;
    if ({cmd_start, l3_en, cmd_out} !== {2'b11, 8'h11}) begin
      n_fail++; $display("FAIL rstmid_accept got start=%0b en=%0b cmd=%02h exp 1 1 11", cmd_start, l3_en, cmd_out);
    end
    tick();
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    n_tests++;
    if ({bus.rsp_valid, bus.rsp_status, bus.rsp_retries} !== 5'b1_00_00) begin
      n_fail++; $display("FAIL rstmid_resp got v=%0b st=%0d rt=%0d exp 1 0 0", bus.rsp_valid, bus.rsp_status, bus.rsp_retries);
    end
    handshake();
  endtask

  task automatic test_no_retry();
    bus0.req_valid = 1'b1;
    bus0.req_cmd   = 8'hC3;
    tick();
    bus0.req_valid = 1'b0;
    tick();                                  // WAIT
    err_timeout0 = 1'b1;
    #1;
    n_tests++;
    if (cmd_abort0 !== 1'b1) begin n_fail++; $display("FAIL r0_abort got %0b exp 1", cmd_abort0); end
    tick();
    err_timeout0 = 1'b0;
    n_tests++;
    if ({bus0.rsp_valid, bus0.rsp_status, bus0.rsp_retries} !== 5'b1_01_00) begin
      n_fail++; $display("FAIL r0_resp got v=%0b st=%0d rt=%0d exp 1 1 0", bus0.rsp_valid, bus0.rsp_status, bus0.rsp_retries);
    end
    bus0.rsp_ready = 1'b1;
    tick();
    bus0.rsp_ready = 1'b0;
  endtask

  task automatic test_pulse_rules();
    tick();
    n_tests++;
    if (viol !== 0) begin n_fail++; $display("FAIL pulse_rules got %0d violations exp 0", viol); end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_cmd = 8'h00; bus.abort_req = 1'b0; bus.rsp_ready = 1'b0;
    bus0.req_valid = 1'b0; bus0.req_cmd = 8'h00; bus0.abort_req = 1'b0; bus0.rsp_ready = 1'b0;
    cmd_done = 1'b0; err_timeout = 1'b0; cmd_done0 = 1'b0; err_timeout0 = 1'b0;
    test_reset();
    test_nominal();
    test_single_retry();
    test_exhausted();
    test_abort();
    test_simultaneous();
    test_backpressure();
    test_reset_mid();
    test_no_retry();
    test_pulse_rules();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/l3_cmd_seq.md
L3_CMD_SEQ -- requirements
Module: l3_cmd_seq

Interface
REQ-001 Parameter CMD_W, default 8: command word width.
REQ-002 Parameter MAX_RETRY, default 2: re-issues allowed after a timeout, range 0..3.
REQ-003 Parameter GAP_CYC, default 4: idle cycles between a timeout and the next re-issue, range 1..15.
REQ-004 clk  input  1  clock; all logic rising-edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  1  host command request.
REQ-007 req_ready  output  1  sequencer accepts a request.
REQ-008 req_cmd  input  CMD_W  command word.
REQ-009 abort_req  input  1  host cancel, level-sampled.
REQ-010 cmd_start  output  1  one-cycle pulse: L3 engine begins the command.
REQ-011 cmd_out  output  CMD_W  latched command to the engine.
REQ-012 cmd_done  input  1  engine completion pulse; the top level also routes it to the watchdog timer's done input.
REQ-013 cmd_abort  output  1  one-cycle pulse: engine drops the current command.
REQ-014 l3_en  output  1  one-cycle pulse: watchdog timer clears and starts.
REQ-015 timer_stop  output  1  one-cycle pulse: watchdog timer clears and stops.
REQ-016 err_timeout  input  1  watchdog expiry, high for one cycle.
REQ-017 rsp_valid  output  1  response available.
REQ-018 rsp_ready  input  1  host consumes the response.
REQ-019 rsp_status  output  2  00 OK, 01 TIMEOUT_FAIL, 10 ABORTED, 11 reserved (never driven).
REQ-020 rsp_retries  output  2  re-issues used for this command.

Function
REQ-021 The FSM SHALL have these states: IDLE, START, WAIT, GAP, RESP.
REQ-022 req_ready SHALL be 1 only in IDLE; a transfer occurs when req_valid and req_ready are both 1, which latches req_cmd into cmd_out, clears the retry count, and moves to START.
REQ-023 START SHALL last exactly one cycle, assert cmd_start and l3_en together, and move to WAIT; cmd_start is therefore seen 1 cycle after acceptance.
REQ-024 WAIT SHALL use this priority: cmd_done, then err_timeout, then abort_req.
REQ-025 WAIT, cmd_done=1: move to RESP with status 00 and no timer_stop.
REQ-026 WAIT, err_timeout=1: pulse cmd_abort the same cycle. If retry count < MAX_RETRY, increment it and move to GAP; otherwise move to RESP with status 01.
REQ-027 WAIT, abort_req=1 (no cmd_done or err_timeout): pulse timer_stop and cmd_abort the same cycle and move to RESP with status 10.
REQ-028 GAP SHALL wait GAP_CYC cycles, then move to START, which re-pulses l3_en and cmd_start with an unchanged cmd_out.
REQ-029 GAP with abort_req=1: pulse timer_stop, move to RESP with status 10, and issue no further cmd_abort (already issued).
REQ-030 RESP SHALL hold rsp_valid=1 and hold rsp_status and rsp_retries stable until rsp_ready=1, then return to IDLE; req_ready rises the cycle after the handshake.
REQ-031 cmd_done, err_timeout and abort_req SHALL be ignored in IDLE, START and RESP.
REQ-032 cmd_start, cmd_abort, l3_en and timer_stop SHALL never be high for 2 consecutive cycles.
REQ-033 l3_en and timer_stop SHALL never be high in the same cycle.
REQ-034 The retry counter SHALL be 2 bits, saturate at MAX_RETRY, and never wrap.
REQ-035 With MAX_RETRY=0, the first timeout SHALL go directly to RESP with status 01 and retries 0.

Reset
REQ-036 While rst_n=0, the FSM SHALL be in IDLE with req_ready=1 and all of the following at 0: cmd_start, cmd_abort, l3_en, timer_stop, rsp_valid, rsp_status, rsp_retries, cmd_out, retry count, gap count.
REQ-037 Reset asserted mid-command SHALL take effect immediately with no cmd_abort or timer_stop pulse; the timer is reset by the same rst_n.
REQ-038 The first request SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-039 Nominal: req_cmd=0xA5 accepted at cycle 0 -> cmd_start and l3_en at cycle 1, cmd_out=0xA5; cmd_done at cycle 10 -> rsp_valid at cycle 11, status 00, retries 0.
REQ-040 Single retry: err_timeout in WAIT -> cmd_abort the same cycle; after 4 GAP cycles l3_en and cmd_start re-pulse with cmd_out still 0xA5; then cmd_done -> status 00, retries 1.
REQ-041 Exhausted retries (MAX_RETRY=2): three timeouts -> exactly 3 cmd_start pulses and 3 cmd_abort pulses, then status 01, retries 2.
REQ-042 Host abort: abort_req in WAIT -> timer_stop and cmd_abort pulses, status 10; abort_req held in GAP -> timer_stop only, status 10.
REQ-043 Simultaneous: cmd_done, err_timeout and abort_req all 1 in WAIT -> status 00, no cmd_abort, no timer_stop.
REQ-044 Backpressure and reset: rsp_ready held 0 for 20 cycles -> rsp_valid and rsp fields stable and req_ready=0; rst_n pulsed low in WAIT -> outputs at reset values with no pulses, and the next request is accepted normally.
